// File: rtl/pipelined_control_unit.sv
// Registered ID/EX control decoder: one cycle of control per accepted opcode,
// with a multi-cycle MUL sequencer, stall/flush handling and a sticky panic state.
module pipelined_control_unit #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALU_TYPE_W  = 4,
    parameter int unsigned BR_TYPE_W   = 4,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned MAX_OPCODE  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [1:0]            funct,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic                  alu_operation,
    output logic [ALU_TYPE_W-1:0] alu_operation_type,
    output logic                  write_register,
    output logic                  load_word_memory,
    output logic                  store_word_memory,
    output logic                  branch,
    output logic [BR_TYPE_W-1:0]  branch_operation_type,
    output logic                  jump,
    output logic                  mul_busy,
    output logic                  panic
);

    localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {StRun, StMulBusy, StPanic} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  alu;
        logic [ALU_TYPE_W-1:0] alu_type;
        logic                  wr;
        logic                  lw;
        logic                  sw;
        logic                  br;
        logic [BR_TYPE_W-1:0]  br_type;
        logic                  jump;
    } ctrl_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = '0;
        if (flush) begin
            // Flush kills the bundle and any MUL in flight, but never clears panic.
            if (state_q != StPanic) state_d = StRun;
            cnt_d = '0;
        end else if (stall) begin
            ctrl_d = ctrl_q;
        end else begin
            case (state_q)
                StRun: begin
                    if (in_valid) begin
                        case (opcode)
                            OPCODE_W'(0): begin
                                ctrl_d.valid    = 1'b1;
                                ctrl_d.alu      = 1'b1;
                                ctrl_d.alu_type = ALU_TYPE_W'(funct) + ALU_TYPE_W'(1);
                                ctrl_d.wr       = 1'b1;
                            end
                            OPCODE_W'(1): begin
                                ctrl_d.valid = 1'b1;
                                ctrl_d.lw    = 1'b1;
                                ctrl_d.wr    = 1'b1;
                            end
                            OPCODE_W'(2): begin
                                ctrl_d.valid = 1'b1;
                                ctrl_d.sw    = 1'b1;
                            end
                            OPCODE_W'(3): begin
                                ctrl_d.valid   = 1'b1;
                                ctrl_d.br      = 1'b1;
                                ctrl_d.br_type = BR_TYPE_W'(1);
                            end
                            OPCODE_W'(4): begin
                                ctrl_d.valid   = 1'b1;
                                ctrl_d.br      = 1'b1;
                                ctrl_d.br_type = BR_TYPE_W'(2);
                            end
                            OPCODE_W'(5): begin
                                ctrl_d.valid   = 1'b1;
                                ctrl_d.br      = 1'b1;
                                ctrl_d.br_type = BR_TYPE_W'(3);
                            end
                            OPCODE_W'(6): begin
                                ctrl_d.valid = 1'b1;
                                ctrl_d.jump  = 1'b1;
                            end
                            OPCODE_W'(7): begin
                                ctrl_d.valid    = 1'b1;
                                ctrl_d.alu      = 1'b1;
                                ctrl_d.alu_type = ALU_TYPE_W'(5);
                                state_d         = StMulBusy;
                                cnt_d           = CNT_W'(MUL_LATENCY - 1);
                            end
                            default: begin
                                if (32'(opcode) > MAX_OPCODE) state_d = StPanic;
                                else ctrl_d.valid = 1'b1;
                            end
                        endcase
                    end
                end
                StMulBusy: begin
                    if (cnt_q == '0) begin
                        ctrl_d.valid    = 1'b1;
                        ctrl_d.alu      = 1'b1;
                        ctrl_d.alu_type = ALU_TYPE_W'(5);
                        ctrl_d.wr       = 1'b1;
                        state_d         = StRun;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign in_ready              = (state_q == StRun) && !stall;
    assign out_valid             = ctrl_q.valid;
    assign alu_operation         = ctrl_q.alu;
    assign alu_operation_type    = ctrl_q.alu_type;
    assign write_register        = ctrl_q.wr;
    assign load_word_memory      = ctrl_q.lw;
    assign store_word_memory     = ctrl_q.sw;
    assign branch                = ctrl_q.br;
    assign branch_operation_type = ctrl_q.br_type;
    assign jump                  = ctrl_q.jump;
    assign mul_busy              = (state_q == StMulBusy);
    assign panic                 = (state_q == StPanic);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipelined_control_unit;

    localparam int unsigned L      = 4;
    localparam int unsigned MAX_OP = 10;

    logic       clk = 1'b0;
    logic       reset_n, in_valid, in_ready, stall, flush;
    logic [3:0] opcode;
    logic [1:0] funct;
    logic       out_valid, alu_operation, write_register, load_word_memory;
    logic       store_word_memory, branch, jump, mul_busy, panic;
    logic [3:0] alu_operation_type, branch_operation_type;

    int checks   = 0;
    int failures = 0;

    // Model state: pending MUL cycles (0 = none in flight) and the expected bundle.
    int       m_mul_left;
    bit       m_panic;
    bit       m_v, m_a, m_w, m_l, m_s, m_b, m_j;
    bit [3:0] m_at, m_bt;

    pipelined_control_unit #(
        .OPCODE_W   (4),
        .ALU_TYPE_W (4),
        .BR_TYPE_W  (4),
        .MUL_LATENCY(L),
        .MAX_OPCODE (MAX_OP)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .opcode               (opcode),
        .funct                (funct),
        .stall                (stall),
        .flush                (flush),
        .out_valid            (out_valid),
        .alu_operation        (alu_operation),
        .alu_operation_type   (alu_operation_type),
        .write_register       (write_register),
        .load_word_memory     (load_word_memory),
        .store_word_memory    (store_word_memory),
        .branch               (branch),
        .branch_operation_type(branch_operation_type),
        .jump                 (jump),
        .mul_busy             (mul_busy),
        .panic                (panic)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] bundle(input bit v, input bit a, input int at, input bit w,
                                           input bit l, input bit s, input bit b, input int bt,
                                           input bit j, input bit mb, input bit p);
        logic [3:0] at4, bt4;
        at4 = at[3:0];
        bt4 = bt[3:0];
        return {v, a, at4, w, l, s, b, bt4, j, mb, p};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {out_valid, alu_operation, alu_operation_type, write_register, load_word_memory,
                store_word_memory, branch, branch_operation_type, jump, mul_busy, panic};
    endfunction

    function automatic logic [16:0] model_vec();
        return bundle(m_v, m_a, int'(m_at), m_w, m_l, m_s, m_b, int'(m_bt), m_j,
                      m_mul_left > 0, m_panic);
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bubble();
        {m_v, m_a, m_w, m_l, m_s, m_b, m_j} = '0;
        m_at = '0;
        m_bt = '0;
    endtask

    task automatic model_update(input bit r, input bit v, input int op, input int fn,
                                input bit st, input bit fl);
        if (!r) begin
            bubble();
            m_mul_left = 0;
            m_panic    = 0;
        end else if (fl) begin
            bubble();
            m_mul_left = 0;
        end else if (st) begin
            // everything holds
        end else if (m_panic) begin
            bubble();
        end else if (m_mul_left > 0) begin
            bubble();
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_v = 1; m_a = 1; m_at = 5; m_w = 1;
            end
        end else begin
            bubble();
            if (v) begin
                if (op > MAX_OP) m_panic = 1;
                else begin
                    m_v = 1;
                    if (op == 0) begin m_a = 1; m_w = 1; m_at = 4'(fn + 1); end
                    if (op == 1) begin m_l = 1; m_w = 1; end
                    if (op == 2) m_s = 1;
                    if (op >= 3 && op <= 5) begin m_b = 1; m_bt = 4'(op - 2); end
                    if (op == 6) m_j = 1;
                    if (op == 7) begin m_a = 1; m_at = 5; m_mul_left = L; end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, check at the negedge, advance the model at the edge.
    task automatic step(input bit r, input bit v, input int op, input int fn,
                        input bit st, input bit fl);
        bit exp_ready;
        reset_n  = r;
        in_valid = v;
        opcode   = 4'(op);
        funct    = 2'(fn);
        stall    = st;
        flush    = fl;
        @(negedge clk);
        exp_ready = !m_panic && (m_mul_left == 0) && !st;
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL bundle t=%0t actual=%h expected=%h", $time, dut_vec(), model_vec());
        end
        checks++;
        if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_ready t=%0t actual=%b expected=%b", $time, in_ready, exp_ready);
        end
        @(posedge clk);
        model_update(r, v, op, fn, st, fl);
        #1;
    endtask

    logic [16:0] exp7[7];
    logic [16:0] add_b, mul_issue, mul_wb;
    int          ops7[7];
    int          k, busy_cnt, wb_cnt;

    initial begin
        ops7 = '{0, 1, 2, 3, 4, 5, 6};
        exp7[0] = bundle(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        exp7[1] = bundle(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        exp7[2] = bundle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        exp7[3] = bundle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        exp7[4] = bundle(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        exp7[5] = bundle(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        exp7[6] = bundle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add_b     = bundle(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        mul_issue = bundle(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        mul_wb    = bundle(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);

        m_mul_left = 0;
        m_panic    = 0;
        bubble();
        reset_n = 0; in_valid = 0; opcode = 0; funct = 0; stall = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_bundle", int'(dut_vec()), 0);
        lit("reset_ready", int'(in_ready), 1);

        // Back-to-back decode, one per cycle
        for (int i = 0; i < 7; i++) begin
            step(1, 1, ops7[i], 1, 0, 0);
            lit($sformatf("decode_op%0d", ops7[i]), int'(dut_vec()), int'(exp7[i]));
        end

        // MUL without stall: writeback 4 cycles after issue, busy for 4 cycles
        step(1, 1, 7, 0, 0, 0);
        lit("mul_issue", int'(dut_vec()), int'(mul_issue));
        busy_cnt = int'(mul_busy);
        for (k = 1; k <= 20; k++) begin
            step(1, 1, 1, 0, 0, 0);
            if (out_valid && write_register && alu_operation_type == 4'd5) break;
            if (mul_busy) busy_cnt++;
        end
        lit("mul_wb_latency", k, L);
        lit("mul_wb_bundle", int'(dut_vec()), int'(mul_wb));
        lit("mul_busy_cycles", busy_cnt, L);

        // MUL with a two-cycle stall mid-busy: writeback pushed out by 2
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0);
        for (k = 1; k <= 20; k++) begin
            step(1, 1, 0, 0, (k == 2 || k == 3), 0);
            if (out_valid && write_register && alu_operation_type == 4'd5) break;
        end
        lit("mul_wb_stalled_latency", k, L + 2);

        // Stall holds an ADD bundle, ignores in_valid
        step(1, 1, 0, 0, 0, 0);
        lit("add_accept", int'(dut_vec()), int'(add_b));
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 1, 0);
            lit("stall_hold", int'(dut_vec()), int'(add_b));
            lit("stall_ready", int'(in_ready), 0);
        end

        // Flush two cycles into a MUL
        step(1, 1, 7, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        lit("flush_bubble", int'(dut_vec()), 0);
        wb_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (out_valid) wb_cnt++;
        end
        lit("flush_no_wb", wb_cnt, 0);
        step(1, 1, 0, 0, 0, 0);
        lit("post_flush_add", int'(dut_vec()), int'(add_b));

        // Panic is sticky through traffic and flush, cleared by reset
        step(1, 1, 11, 0, 0, 0);
        lit("panic_set", int'(dut_vec()), 1);
        lit("panic_ready", int'(in_ready), 0);
        step(1, 1, 0, 0, 0, 0);
        lit("panic_ignores_add", int'(dut_vec()), 1);
        step(1, 0, 0, 0, 0, 1);
        lit("panic_survives_flush", int'(dut_vec()), 1);
        step(0, 0, 0, 0, 0, 0);
        lit("panic_reset", int'(dut_vec()), 0);
        lit("panic_reset_ready", int'(in_ready), 1);
        step(1, 1, 12, 0, 0, 1);
        lit("flushed_illegal_no_panic", int'(dut_vec()), 0);
        step(1, 0, 0, 0, 0, 0);

        // Reset during MUL_BUSY
        step(1, 1, 7, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        lit("mul_reset_bundle", int'(dut_vec()), 0);
        lit("mul_reset_ready", int'(in_ready), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = ($urandom_range(0, 99) < 1) ? int'($urandom_range(11, 15))
                                             : int'($urandom_range(0, 10));
            step($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 70, op,
                 int'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered, pipelined successor to the single-cycle opcode decoder; sits at the ID/EX boundary of the pipelined core.
- Decodes each accepted instruction into one cycle of registered control signals.
- Adds a funct-selected ALU op, a multi-cycle MUL sequencer, stall/flush handling and a sticky panic state.

Parameters:
- OPCODE_W, 4, opcode width.
- ALU_TYPE_W, 4, alu_operation_type width.
- BR_TYPE_W, 4, branch_operation_type width.
- MUL_LATENCY, 4, cycles from MUL issue to MUL writeback. Legal range ≥1.
- MAX_OPCODE, 10, highest legal opcode. Any higher opcode raises panic.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_valid  in  1  opcode/funct valid from fetch.
- in_ready  out  1  unit can accept an instruction this cycle.
- opcode  in  OPCODE_W  instruction opcode.
- funct  in  2  ALU sub-op for opcode 0.
- stall  in  1  hold output register, accept nothing.
- flush  in  1  kill current output and any MUL in flight.
- out_valid  out  1  registered control bundle valid.
- alu_operation  out  1  ALU instruction.
- alu_operation_type  out  ALU_TYPE_W  1=ADD, 2=SUB, 3=AND, 4=OR, 5=MUL.
- write_register  out  1  register-file write enable.
- load_word_memory  out  1  LW.
- store_word_memory  out  1  SW.
- branch  out  1  conditional branch.
- branch_operation_type  out  BR_TYPE_W  1=BEQ, 2=BGT, 3=BGE.
- jump  out  1  JUMP.
- mul_busy  out  1  MUL in flight.
- panic  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (reset_n=0 at clk edge): state=RUN; all outputs 0; MUL counter 0. reset_n wins over every other input, including mid-MUL and in PANIC.
- States: RUN, MUL_BUSY, PANIC.
- in_ready = (state==RUN) && !stall.
- accept = in_valid && in_ready && !flush.
- Decode latency: exactly 1 cycle. Accept at edge N → bundle visible after edge N, out_valid=1 for that cycle.
- Without a new accept (and without stall), the output register loads a bubble: all control outputs 0, out_valid=0.
- Opcode map:
  - 0: ALU op. alu_operation=1, write_register=1. Type from funct: 0→1, 1→2, 2→3, 3→4.
  - 1: LW. load_word_memory=1, write_register=1.
  - 2: SW. store_word_memory=1.
  - 3/4/5: branch=1; branch_operation_type 1/2/3 respectively.
  - 6: jump=1.
  - 7: MUL. Issue bundle: alu_operation=1, type=5, write_register=0. State→MUL_BUSY; counter loads MUL_LATENCY-1.
  - 8..MAX_OPCODE: legal NOP. out_valid=1, all controls 0.
  - >MAX_OPCODE: state→PANIC.
- Unused type fields are 0 whenever the corresponding class bit is 0.
- MUL_BUSY:
  - mul_busy=1; in_ready=0.
  - Counter decrements each non-stalled cycle; it holds under stall.
  - When counter==0 and not stalled: output register loads the writeback bundle (out_valid=1, write_register=1, alu_operation=1, type=5), then state→RUN.
  - Total: writeback appears exactly MUL_LATENCY cycles after the issue bundle, plus stall cycles.
- stall=1: output register and counter hold; no accept. out_valid keeps its value.
- flush=1:
  - Takes precedence over stall and in_valid.
  - Next cycle the output is a bubble.
  - In MUL_BUSY: abort MUL, state→RUN, no writeback, mul_busy→0.
  - Flush and an illegal opcode in the same cycle → no panic, since the instruction is not accepted.
- PANIC:
  - panic=1 from the cycle after acceptance of the illegal opcode.
  - out_valid=0, in_ready=0, mul_busy=0.
  - Flush does not clear it; only reset does.
- Counter width is clog2(MUL_LATENCY+1). With MUL_LATENCY=1, writeback follows issue on the next cycle.

Test Plan:
- Reset, then accept opcodes 0/funct=1, 1, 2, 3, 4, 5, 6 back-to-back → one cycle later each: (alu=1, type=2, wr=1), (lw=1, wr=1), (sw=1), (br=1, type=1), (br=1, type=2), (br=1, type=3), (jump=1); out_valid=1 on all seven cycles.
- MUL_LATENCY=4, accept opcode 7 → issue bundle (type=5, wr=0); mul_busy=1 and in_ready=0 for 4 cycles; writeback (wr=1, type=5) exactly 4 cycles after issue. Stall for 2 cycles mid-busy → writeback delayed to 6 cycles after issue.
- Stall asserted for 3 cycles with ADD held in the output register → bundle constant; in_valid ignored; in_ready=0.
- Flush 2 cycles into a MUL → bubble next cycle, mul_busy=0, no writeback ever; next ADD accepted with 1-cycle latency.
- Accept opcode 11 → panic=1 next cycle; subsequent valid ADD and a flush leave panic=1, out_valid=0. reset_n=0 → all outputs 0. Also: opcode 12 with flush=1 → no panic.
- reset_n=0 during MUL_BUSY → next cycle state RUN, mul_busy=0, out_valid=0, in_ready=1.
